// File: rtl/konverter_pkg.sv
// Shared constants and types for the burst deserializer slice: default sizing,
// the receive state encoding and the frame-counter width.
package konverter_pkg;

  localparam int DEF_WORD_BITS   = 32;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int FRAME_CNT_W     = 8;

  typedef enum logic [1:0] {
    ARMWAIT,
    IDLE,
    SHIFT,
    TAIL
  } deser_state_e;

  // Width needed to hold the values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/burst_deserializer_if.sv
// Burst input and word-output bundle of the burst deserializer. The master side
// is the upstream burst source plus the word consumer; the slave side is the deserializer.
interface burst_deserializer_if #(
  parameter int WORD_BITS = konverter_pkg::DEF_WORD_BITS
);

  logic                                 burst_en;
  logic                                 burst_clk;
  logic                                 burst_data;
  logic [WORD_BITS-1:0]                 out_data;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [konverter_pkg::FRAME_CNT_W-1:0] frame_cnt;
  logic                                 busy;
  logic                                 err_len;
  logic                                 err_ovf;
  logic                                 err_clr;

  modport master (
    output burst_en, burst_clk, burst_data, out_ready, err_clr,
    input  out_data, out_valid, frame_cnt, busy, err_len, err_ovf
  );

  modport slave (
    input  burst_en, burst_clk, burst_data, out_ready, err_clr,
    output out_data, out_valid, frame_cnt, busy, err_len, err_ovf
  );

endinterface

// File: rtl/bit_sync.sv
// Single-bit synchronizer: a chain of STAGES flops bringing an asynchronous
// level into the clk domain. Resets to 0.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // NOTE: non-blocking (<=) in clocked blocks so each flop samples its neighbour's pre-edge value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/deser_fifo2.sv
// Two-entry valid/ready word buffer built as a head and a tail register, so
// data_o/valid_o come straight from flops and the head is held until popped.
module deser_fifo2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             accept_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic             head_v_q, head_v_d, tail_v_q, tail_v_d;
  logic             pop, full;

  assign pop  = head_v_q & ready_i;
  assign full = head_v_q & tail_v_q;

  // A pop in the push cycle frees a slot first, so a full buffer still accepts.
  assign accept_o = push_i & (~full | pop);
  assign ovf_o    = push_i & full & ~pop;

  // NOTE: every always_comb output is given a default first, so no path can infer a latch.
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    head_v_d = head_v_q;
    tail_v_d = tail_v_q;
    if (pop) begin
      head_d   = tail_q;
      head_v_d = tail_v_q;
      tail_v_d = 1'b0;
    end
    if (accept_o) begin
      if (!head_v_d) begin
        head_d   = push_data_i;
        head_v_d = 1'b1;
      end else begin
        tail_d   = push_data_i;
        tail_v_d = 1'b1;
      end
    end
  end

  // NOTE: the data registers are reset too, because out_data must read 0 out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      head_v_q <= 1'b0;
      tail_v_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      head_v_q <= head_v_d;
      tail_v_q <= tail_v_d;
    end
  end

  assign data_o  = head_q;
  assign valid_o = head_v_q;

endmodule

// File: rtl/burst_deserializer.sv
// Recovers one WORD_BITS word per gated burst_clk burst in the clk domain and
// hands it to a two-entry output buffer, flagging malformed bursts and overflow.
module burst_deserializer
  import konverter_pkg::*;
#(
  parameter int WORD_BITS   = DEF_WORD_BITS,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  burst_deserializer_if.slave bus
);

  localparam int CNT_W = cnt_width(WORD_BITS);
  localparam int ARM_W = cnt_width(SYNC_STAGES);

  logic                   en_s, ck_s, d_s;
  logic                   ck_s_d1_q;
  logic                   ck_rise;
  deser_state_e           state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ARM_W-1:0]       arm_q, arm_d;
  logic                   arm_done;
  logic [WORD_BITS-1:0]   sreg_q, sreg_d, shift_in;
  logic                   push, push_accept, push_ovf, len_err;
  logic                   err_len_q, err_len_d, err_ovf_q, err_ovf_d;
  logic [FRAME_CNT_W-1:0] frame_q, frame_d;

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync_en (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (bus.burst_en),
    .q_o     (en_s)
  );

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync_ck (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (bus.burst_clk),
    .q_o     (ck_s)
  );

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync_d (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (bus.burst_data),
    .q_o     (d_s)
  );

  assign ck_rise = ck_s & ~ck_s_d1_q;

  if (MSB_FIRST) begin : g_msb_first
    assign shift_in = (sreg_q << 1) | WORD_BITS'(d_s);
  end else begin : g_lsb_first
    assign shift_in = (sreg_q >> 1) | {d_s, {(WORD_BITS-1){1'b0}}};
  end

  // The synchronizers come out of reset at 0, so en_s only reflects the real
  // burst_en once the chain has refilled; until then ARMWAIT must not trust it.
  assign arm_done = (arm_q == ARM_W'(SYNC_STAGES));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    push    = 1'b0;
    len_err = 1'b0;
    case (state_q)
      ARMWAIT: begin
        if (arm_done && !en_s) state_d = IDLE;
      end
      IDLE: begin
        if (en_s) begin
          state_d = SHIFT;
          cnt_d   = '0;
          sreg_d  = '0;
        end
      end
      SHIFT: begin
        // Enable falling wins over a coincident edge; the partial word is dropped.
        if (!en_s) begin
          len_err = 1'b1;
          state_d = IDLE;
        end else if (ck_rise) begin
          sreg_d = shift_in;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WORD_BITS - 1)) begin
            push    = 1'b1;
            state_d = TAIL;
          end
        end
      end
      TAIL: begin
        if (!en_s) begin
          state_d = IDLE;
        end else if (ck_rise) begin
          len_err = 1'b1;
        end
      end
      default: state_d = ARMWAIT;
    endcase
  end

  // Set beats clear when both land in the same cycle.
  always_comb begin
    err_len_d = len_err | (err_len_q & ~bus.err_clr);
    err_ovf_d = push_ovf | (err_ovf_q & ~bus.err_clr);
    frame_d   = push_accept ? frame_q + FRAME_CNT_W'(1) : frame_q;
    arm_d     = arm_done ? arm_q : arm_q + ARM_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ARMWAIT;
      cnt_q     <= '0;
      arm_q     <= '0;
      sreg_q    <= '0;
      ck_s_d1_q <= 1'b0;
      err_len_q <= 1'b0;
      err_ovf_q <= 1'b0;
      frame_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      arm_q     <= arm_d;
      sreg_q    <= sreg_d;
      ck_s_d1_q <= ck_s;
      err_len_q <= err_len_d;
      err_ovf_q <= err_ovf_d;
      frame_q   <= frame_d;
    end
  end

  // The completed word goes straight from the shift path into the buffer, so it
  // is visible on out_data one cycle after the last ck_rise.
  deser_fifo2 #(.WIDTH(WORD_BITS)) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push),
    .push_data_i (shift_in),
    .ready_i     (bus.out_ready),
    .data_o      (bus.out_data),
    .valid_o     (bus.out_valid),
    .accept_o    (push_accept),
    .ovf_o       (push_ovf)
  );

  assign bus.frame_cnt = frame_q;
  assign bus.busy      = (state_q == SHIFT);
  assign bus.err_len   = err_len_q;
  assign bus.err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_burst_deserializer.sv
// Bench for burst_deserializer: a 32-bit MSB-first instance and an 8-bit
// LSB-first instance, driven with directed and $urandom bursts against a word-level model.
module tb_burst_deserializer;

  localparam int PH   = 4;  // burst_clk half period in clk cycles
  localparam int SYNC = 2;

  logic clk;
  logic reset_n;

  burst_deserializer_if #(.WORD_BITS(32)) if32 ();
  burst_deserializer_if #(.WORD_BITS(8))  if8  ();

  burst_deserializer #(.WORD_BITS(32), .SYNC_STAGES(SYNC), .MSB_FIRST(1'b1)) dut32 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if32)
  );

  burst_deserializer #(.WORD_BITS(8), .SYNC_STAGES(SYNC), .MSB_FIRST(1'b0)) dut8 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if8)
  );

  // Index 0 drives/observes the 32-bit instance, index 1 the 8-bit one.
  logic        b_en [2];
  logic        b_ck [2];
  logic        b_d  [2];
  logic        o_rdy[2];
  logic        e_clr[2];
  logic [63:0] o_data [2];
  logic        o_valid[2];
  logic [7:0]  o_frame[2];
  logic        o_busy [2];
  logic        o_len  [2];
  logic        o_ovf  [2];

  assign if32.burst_en   = b_en[0];
  assign if32.burst_clk  = b_ck[0];
  assign if32.burst_data = b_d[0];
  assign if32.out_ready  = o_rdy[0];
  assign if32.err_clr    = e_clr[0];
  assign if8.burst_en    = b_en[1];
  assign if8.burst_clk   = b_ck[1];
  assign if8.burst_data  = b_d[1];
  assign if8.out_ready   = o_rdy[1];
  assign if8.err_clr     = e_clr[1];

  assign o_data[0]  = 64'(if32.out_data);
  assign o_valid[0] = if32.out_valid;
  assign o_frame[0] = if32.frame_cnt;
  assign o_busy[0]  = if32.busy;
  assign o_len[0]   = if32.err_len;
  assign o_ovf[0]   = if32.err_ovf;
  assign o_data[1]  = 64'(if8.out_data);
  assign o_valid[1] = if8.out_valid;
  assign o_frame[1] = if8.frame_cnt;
  assign o_busy[1]  = if8.busy;
  assign o_len[1]   = if8.err_len;
  assign o_ovf[1]   = if8.err_ovf;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-level reference: buffered words, frame count and sticky flags.
  logic [63:0] mq[$];
  int          m_cnt;
  bit          m_len;
  bit          m_ovf;
  bit          tx_bits[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int wbits(input int sel);
    return (sel == 0) ? 32 : 8;
  endfunction

  function automatic bit msbf(input int sel);
    return (sel == 0);
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic void model_reset();
    mq.delete();
    m_cnt = 0;
    m_len = 0;
    m_ovf = 0;
  endfunction

  // Serial order of a word; bits beyond the word length are random.
  task automatic load_word(input int sel, input logic [63:0] word, input int n);
    int w;
    w = wbits(sel);
    tx_bits.delete();
    for (int i = 0; i < n; i++) begin
      if (i < w) tx_bits.push_back(msbf(sel) ? word[w-1-i] : word[i]);
      else       tx_bits.push_back(1'($urandom));
    end
  endtask

  // Outcome of one complete burst: the first w bits form the word.
  function automatic void model_burst(input int sel);
    int          w;
    logic [63:0] word;
    w    = wbits(sel);
    word = '0;
    if (tx_bits.size() < w) begin
      m_len = 1;
      return;
    end
    if (tx_bits.size() > w) m_len = 1;
    for (int i = 0; i < w; i++) begin
      if (msbf(sel)) word[w-1-i] = tx_bits[i];
      else           word[i]     = tx_bits[i];
    end
    if (mq.size() < 2) begin
      mq.push_back(word);
      m_cnt = (m_cnt + 1) % 256;
    end else begin
      m_ovf = 1;
    end
  endfunction

  task automatic compare_all(input int sel, input string tag);
    check({tag, ".valid"}, o_valid[sel], (mq.size() > 0));
    if (mq.size() > 0) check({tag, ".data"}, o_data[sel], mq[0]);
    check({tag, ".frame"}, o_frame[sel], m_cnt);
    check({tag, ".busy"}, o_busy[sel], 0);
    check({tag, ".err_len"}, o_len[sel], m_len);
    check({tag, ".err_ovf"}, o_ovf[sel], m_ovf);
  endtask

  task automatic start_burst(input int sel);
    b_en[sel] = 1'b1;
    wait_clk(4);
  endtask

  // One bit period; with pop_at_push the consumer accepts exactly in the cycle
  // the completed word is pushed (SYNC cycles after the rise, plus one).
  task automatic bit_edge(input int sel, input bit b, input bit pop_at_push);
    b_d[sel] = b;
    wait_clk(PH);
    b_ck[sel] = 1'b1;
    if (pop_at_push) begin
      wait_clk(SYNC);
      o_rdy[sel] = 1'b1;
      wait_clk(1);
      o_rdy[sel] = 1'b0;
      wait_clk(PH - SYNC - 1);
    end else begin
      wait_clk(PH);
    end
    b_ck[sel] = 1'b0;
  endtask

  task automatic end_burst(input int sel);
    wait_clk(PH);
    b_en[sel] = 1'b0;
    wait_clk(8);
  endtask

  task automatic send(input int sel, input bit pop_last);
    int n;
    n = tx_bits.size();
    if (pop_last && mq.size() > 0) check("coin.head", o_data[sel], mq[0]);
    start_burst(sel);
    for (int i = 0; i < n; i++) begin
      bit_edge(sel, tx_bits[i], pop_last && (i == n - 1));
      if (i == 0) check("busy_mid", o_busy[sel], 1);
    end
    end_burst(sel);
    if (pop_last) void'(mq.pop_front());
    model_burst(sel);
  endtask

  task automatic pop_one(input int sel, input string tag);
    if (mq.size() == 0) return;
    check({tag, ".valid"}, o_valid[sel], 1);
    check({tag, ".data"}, o_data[sel], mq[0]);
    o_rdy[sel] = 1'b1;
    wait_clk(1);
    o_rdy[sel] = 1'b0;
    void'(mq.pop_front());
  endtask

  task automatic drain(input int sel, input string tag);
    while (mq.size() > 0) pop_one(sel, tag);
    check({tag, ".empty"}, o_valid[sel], 0);
  endtask

  task automatic clr_err(input int sel);
    e_clr[sel] = 1'b1;
    wait_clk(1);
    e_clr[sel] = 1'b0;
    m_len = 0;
    m_ovf = 0;
  endtask

  task automatic drive_idle();
    for (int s = 0; s < 2; s++) begin
      b_en[s]  = 1'b0;
      b_ck[s]  = 1'b0;
      b_d[s]   = 1'b0;
      o_rdy[s] = 1'b0;
      e_clr[s] = 1'b0;
    end
  endtask

  task automatic do_reset();
    drive_idle();
    reset_n = 1'b0;
    wait_clk(3);
    reset_n = 1'b1;
    wait_clk(6);
    model_reset();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive_idle();
    reset_n = 1'b0;
    model_reset();
    wait_clk(3);

    // Reset state of both instances.
    for (int s = 0; s < 2; s++) begin
      check("rst.data", o_data[s], 0);
      check("rst.valid", o_valid[s], 0);
      check("rst.frame", o_frame[s], 0);
      check("rst.busy", o_busy[s], 0);
      check("rst.err_len", o_len[s], 0);
      check("rst.err_ovf", o_ovf[s], 0);
    end
    reset_n = 1'b1;
    wait_clk(6);

    // Reset after 10 of 32 edges, released with burst_en still high.
    load_word(0, 64'h1357_9BDF, 32);
    start_burst(0);
    for (int i = 0; i < 32; i++) begin
      if (i == 10) begin
        reset_n = 1'b0;
        wait_clk(2);
        reset_n = 1'b1;
        model_reset();
      end
      bit_edge(0, tx_bits[i], 1'b0);
    end
    end_burst(0);
    compare_all(0, "rstmid");

    load_word(0, 64'hA5C3_0F81, 32);
    send(0, 1'b0);
    compare_all(0, "after_rst");
    check("after_rst.literal", o_data[0], 64'hA5C3_0F81);
    check("after_rst.frame1", o_frame[0], 1);
    drain(0, "after_rst");

    // Three back-to-back bursts with no consumer: third one is dropped.
    do_reset();
    load_word(0, 64'h0000_0001, 32);
    send(0, 1'b0);
    compare_all(0, "b2b1");
    load_word(0, 64'h8000_0000, 32);
    send(0, 1'b0);
    compare_all(0, "b2b2");
    check("b2b.hold2", o_data[0], 64'h1);
    load_word(0, 64'hFFFF_FFFF, 32);
    send(0, 1'b0);
    compare_all(0, "b2b3");
    check("b2b.hold3", o_data[0], 64'h1);
    check("b2b.ovf", o_ovf[0], 1);
    check("b2b.frame", o_frame[0], 2);
    pop_one(0, "b2b.pop1");
    check("b2b.second", o_data[0], 64'h8000_0000);
    drain(0, "b2b");
    clr_err(0);
    compare_all(0, "b2b.clr");

    // Short burst: 31 edges.
    load_word(0, 64'(32'hDEAD_BEEF), 31);
    send(0, 1'b0);
    compare_all(0, "short");
    check("short.err_len", o_len[0], 1);
    clr_err(0);
    compare_all(0, "short.clr");
    check("short.cleared", o_len[0], 0);

    // Long burst: 33 edges, first 32 form the word.
    load_word(0, 64'h1234_5678, 33);
    send(0, 1'b0);
    compare_all(0, "long");
    check("long.literal", o_data[0], 64'h1234_5678);
    check("long.err_len", o_len[0], 1);
    drain(0, "long");
    clr_err(0);

    // Push into a full buffer in the same cycle as a pop.
    do_reset();
    load_word(0, 64'h1111_1111, 32);
    send(0, 1'b0);
    load_word(0, 64'h2222_2222, 32);
    send(0, 1'b0);
    load_word(0, 64'h3333_3333, 32);
    send(0, 1'b1);
    compare_all(0, "coin");
    check("coin.ovf", o_ovf[0], 0);
    check("coin.frame", o_frame[0], 3);
    check("coin.order1", o_data[0], 64'h2222_2222);
    pop_one(0, "coin.pop");
    check("coin.order2", o_data[0], 64'h3333_3333);
    drain(0, "coin");

    // Randomized bursts with random lengths, pops and clears.
    do_reset();
    for (int k = 0; k < 40; k++) begin
      int r;
      int n;
      r = int'($urandom_range(0, 9));
      if (r < 6 || r == 9) n = 32;
      else if (r == 6)     n = int'($urandom_range(0, 31));
      else if (r == 7)     n = int'($urandom_range(33, 36));
      else                 n = int'($urandom_range(0, 40));
      load_word(0, {$urandom, $urandom}, n);
      send(0, 1'b0);
      compare_all(0, "rand");
      if ($urandom_range(0, 2) != 0) pop_one(0, "rand.pop");
      if ($urandom_range(0, 4) == 0) begin
        clr_err(0);
        compare_all(0, "rand.clr");
      end
    end
    drain(0, "rand");

    // 8-bit LSB-first: serial 1,0,0,0,0,0,0,0 gives 0x01.
    do_reset();
    tx_bits.delete();
    for (int i = 0; i < 8; i++) tx_bits.push_back(i == 0);
    send(1, 1'b0);
    compare_all(1, "lsb");
    check("lsb.literal", o_data[1], 64'h01);
    pop_one(1, "lsb.pop");

    // frame_cnt across 256 words wraps to 0.
    for (int k = 2; k <= 256; k++) begin
      load_word(1, 64'($urandom), 8);
      send(1, 1'b0);
      compare_all(1, "wrap");
      if (k == 255) check("wrap.255", o_frame[1], 255);
      if (k == 256) check("wrap.0", o_frame[1], 0);
      pop_one(1, "wrap.pop");
    end
    drain(1, "wrap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/burst_deserializer.md
Name: burst_deserializer

Overview:
- Consumes the gated serial-clock burst (burst_en + burst_clk) from the upstream burst generator, together with a serial data line.
- Recovers one WORD_BITS-bit word per burst in the system clock domain and presents it on a valid/ready interface with a 2-entry output buffer.
- Flags malformed bursts and buffer overflow; sits between the framing/burst stage and the byte-level register logic.

Parameters:
- WORD_BITS, 32, bits per burst/word (legal 8..64).
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers (≥2).
- MSB_FIRST, 1, 1: first received bit lands in bit WORD_BITS-1; 0: first received bit lands in bit 0.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous active-low reset.
- burst_en  in  1  async burst enable from upstream (high for the whole burst).
- burst_clk  in  1  async burst clock; data is valid on its rising edge.
- burst_data  in  1  async serial data, stable around burst_clk rise.
- out_data  out  WORD_BITS  head word of the output buffer.
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  consumer accepts the word when out_valid & out_ready.
- frame_cnt  out  8  count of words pushed into the buffer.
- busy  out  1  high while in SHIFT.
- err_len  out  1  sticky: a burst had ≠ WORD_BITS edges.
- err_ovf  out  1  sticky: a complete word was dropped because the buffer was full.
- err_clr  in  1  single-cycle clear of both sticky flags.

Behaviour:
- Reset (async assert, sync release): all outputs 0; buffer empty; bit count 0; state ARMWAIT; synchronizer flops 0.
- Input synchronization:
  - burst_en, burst_clk and burst_data each pass through SYNC_STAGES flops, giving en_s, ck_s and d_s.
  - ck_rise = ck_s & ~ck_s_d1.
  - Bit sampled = d_s in the ck_rise cycle.
  - Input constraint: burst_clk high and low phases ≥ SYNC_STAGES+1 clk periods; data setup/hold ≥ 1 clk period around the burst_clk rise.
- State machine:
  - ARMWAIT: wait for en_s = 0, then go to IDLE. This guarantees that a burst already in progress at reset release is ignored.
  - IDLE: en_s 0→1 → SHIFT; count := 0; shift register := 0.
  - SHIFT: on each ck_rise with en_s = 1, shift in d_s and increment count.
    - The edge that makes count = WORD_BITS pushes the assembled word into the buffer in the next cycle, then the state goes to TAIL.
    - en_s falls with count < WORD_BITS → set err_len, discard partial word, go to IDLE.
  - TAIL: any further ck_rise while en_s = 1 → set err_len (word already delivered). en_s falls → IDLE.
  - A ck_rise in the cycle where en_s is first seen 0 is ignored.
- Latency:
  - Last ck_rise at cycle N → word written at posedge N+1.
  - If the buffer was empty, out_valid = 1 and out_data is correct in cycle N+1.
- Output buffer (2-entry FIFO):
  - out_data/out_valid are registered from the head entry.
  - Push and pop in the same cycle are always legal, including when full: the slot is freed first, so no overflow.
  - Push while full with no pop → word dropped, err_ovf set, frame_cnt not incremented.
  - out_data is held stable while out_valid & ~out_ready.
- frame_cnt: +1 per successful push; wraps 255→0.
- Sticky flags: err_clr clears both flags. If a set event and err_clr occur in the same cycle, set wins.
- busy = (state == SHIFT).

Decomposition:
- Shared package konverter_pkg:
  - Default WORD_BITS and SYNC_STAGES constants.
  - State enum {ARMWAIT, IDLE, SHIFT, TAIL}.
  - Frame-counter width constant (8).
- Sub-modules:
  - bit_sync (parameterised SYNC_STAGES-flop synchronizer, async active-low reset), instantiated three times.
  - deser_fifo2 (2-entry valid/ready word buffer).

Test Plan:
- Reset mid-burst: assert reset_n = 0 after 10 edges of a 32-edge burst, release while burst_en is still high → no word, no error. The next full burst of 0xA5C3_0F81 (MSB_FIRST) → out_data = 0xA5C30F81, frame_cnt = 1.
- Back-to-back: three bursts 0x00000001, 0x80000000, 0xFFFFFFFF with out_ready = 0 → first two buffered, third dropped. Expect err_ovf = 1, frame_cnt = 2, and out_data = 0x00000001 held stable until out_ready is asserted.
- Short burst: 31 edges, then burst_en falls → err_len = 1, no push, busy returns to 0. Then err_clr pulse → err_len = 0.
- Long burst: 33 edges → word from the first 32 edges delivered, err_len = 1.
- Full-buffer push/pop coincidence: buffer full and out_ready = 1 in the push cycle → no err_ovf, frame_cnt increments, word order preserved.
- MSB_FIRST = 0 with WORD_BITS = 8: serial sequence 1,0,0,0,0,0,0,0 → out_data = 0x01. Also run frame_cnt across 256 words → wraps to 0.
